// File: rtl/iob_system_sim_uart_pkg.sv
// Shared definitions for the simulation-side UART endpoint: CSR indices,
// serial frame geometry and the TX/RX state encoding.
package iob_system_sim_uart_pkg;

  localparam int DIV_W     = 16;
  localparam int DATA_BITS = 8;

  // Register index = byte address [4:2]
  typedef enum logic [2:0] {
    CSR_SOFTRESET = 3'd0,
    CSR_DIV       = 3'd1,
    CSR_TXDATA    = 3'd2,
    CSR_TXEN      = 3'd3,
    CSR_RXEN      = 3'd4,
    CSR_TXREADY   = 3'd5,
    CSR_RXREADY   = 3'd6,
    CSR_RXDATA    = 3'd7
  } csr_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/iob_system_sim_uart_if.sv
// IOb-native CSR bus between the bench CPU model (master) and the UART endpoint (slave).
interface iob_system_sim_uart_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                iob_valid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic [DATA_W-1:0]   iob_rdata;
  logic                iob_ready;
  logic                iob_rvalid;

  modport master (
    output iob_valid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rdata, iob_ready, iob_rvalid
  );

  modport slave (
    input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rdata, iob_ready, iob_rvalid
  );
endinterface

// File: rtl/iob_system_sim_uart_phy.sv
// 8N1 serial engines: TX serialiser and RX deserialiser with a 2-FF input
// synchroniser. Bit period is latched from DIV at each frame start.
module iob_system_sim_uart_phy
  import iob_system_sim_uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic                 soft_reset,
  input  logic [DIV_W-1:0]     div,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_byte
);

  function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  uart_state_t          tx_state, rx_state;
  logic [DIV_W-1:0]     tx_div, tx_cnt, rx_div, rx_cnt;
  logic [2:0]           tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_shift, rx_shift;
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 tx_tick, rx_tick;

  assign tx_tick = (tx_state != ST_IDLE) && (tx_cnt == '0);
  assign rx_tick = (rx_state != ST_IDLE) && (rx_cnt == '0);
  assign rx_byte = rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      tx_div   <= DIV_W'(2);
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (cke) begin
      if (soft_reset) begin
        tx_state <= ST_IDLE;
        tx_busy  <= 1'b0;
        txd      <= 1'b1;
      end else if (tx_state == ST_IDLE) begin
        if (tx_start) begin
          tx_state <= ST_START;
          tx_busy  <= 1'b1;
          txd      <= 1'b0;
          tx_div   <= sat_div(div);
          tx_cnt   <= sat_div(div) - DIV_W'(1);
        end
      end else if (!tx_tick) begin
        tx_cnt <= tx_cnt - DIV_W'(1);
      end else begin
        tx_cnt <= tx_div - DIV_W'(1);
        case (tx_state)
          ST_START: begin
            tx_state <= ST_DATA;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end
          ST_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_shift[0];
            end
          end
          default: begin
            tx_state <= ST_IDLE;
            tx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // RX: start is qualified half a bit after the edge, then sampled every bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= ST_IDLE;
      rx_div   <= DIV_W'(2);
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_done  <= 1'b0;
    end else if (cke) begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_done <= 1'b0;
      if (soft_reset || !rx_en) begin
        rx_state <= ST_IDLE;
      end else if (rx_state == ST_IDLE) begin
        if (rx_s3 && !rx_s2) begin
          rx_state <= ST_START;
          rx_div   <= sat_div(div);
          rx_cnt   <= (sat_div(div) >> 1) - DIV_W'(1);
        end
      end else if (!rx_tick) begin
        rx_cnt <= rx_cnt - DIV_W'(1);
      end else begin
        rx_cnt <= rx_div - DIV_W'(1);
        case (rx_state)
          ST_START: begin
            rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
            rx_bit   <= '0;
          end
          ST_DATA: begin
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
          default: begin
            rx_state <= ST_IDLE;
            rx_done  <= rx_s2;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cke) begin
      if (tx_state == ST_IDLE && tx_start) tx_shift <= tx_data;
      else if (tx_tick && tx_state != ST_STOP) tx_shift <= tx_shift >> 1;
      if (rx_tick && rx_state == ST_DATA) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/iob_system_sim_uart.sv
// Bench-side UART endpoint: IOb CSR slave (decode, handshake, register file)
// wrapped around the serial engines.
module iob_system_sim_uart
  import iob_system_sim_uart_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 arst_i,
  iob_system_sim_uart_if.slave iob,
  output logic                 txd_o,
  input  logic                 rxd_i
);

  logic                 ready_q, vld_p1;
  logic [DATA_W-1:0]    rdata_p1, rd_val;
  logic                 soft_reset, tx_en, rx_en, rx_ready;
  logic [DIV_W-1:0]     div_q;
  logic [DATA_BITS-1:0] rx_data, rx_byte;
  logic                 tx_busy, tx_ready, tx_start, rx_done;
  logic                 accept, is_write;
  csr_idx_t             idx;
  logic                 unused_bits;

  assign accept      = iob.iob_valid && ready_q;
  assign is_write    = |iob.iob_wstrb;
  assign idx         = csr_idx_t'(iob.iob_addr[ADDR_W-1 -: 3]);
  assign tx_ready    = tx_en && !soft_reset && !tx_busy;
  assign tx_start    = accept && is_write && (idx == CSR_TXDATA) && tx_ready;
  assign unused_bits = ^{iob.iob_addr[1:0], iob.iob_wdata[DATA_W-1:DIV_W]};

  assign iob.iob_ready  = ready_q;
  assign iob.iob_rvalid = vld_p1;
  assign iob.iob_rdata  = rdata_p1;

  always_comb begin
    rd_val = '0;
    case (idx)
      CSR_TXREADY: rd_val = DATA_W'(tx_ready);
      CSR_RXREADY: rd_val = DATA_W'(rx_ready);
      CSR_RXDATA:  rd_val = DATA_W'(rx_data);
      default:     rd_val = '0;
    endcase
  end

  // Read response stage: accept in cycle N, data and valid in cycle N+1
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      ready_q    <= 1'b0;
      vld_p1     <= 1'b0;
      rdata_p1   <= '0;
      soft_reset <= 1'b0;
      div_q      <= '0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      rx_ready   <= 1'b0;
      rx_data    <= '0;
    end else if (cke_i) begin
      ready_q <= 1'b1;
      vld_p1  <= accept && !is_write;
      if (accept && !is_write) rdata_p1 <= rd_val;
      if (accept && is_write) begin
        case (idx)
          CSR_SOFTRESET: soft_reset <= iob.iob_wdata[0];
          CSR_DIV:       div_q      <= iob.iob_wdata[DIV_W-1:0];
          CSR_TXEN:      tx_en      <= iob.iob_wdata[0];
          CSR_RXEN:      rx_en      <= iob.iob_wdata[0];
          default:       ;
        endcase
      end
      // A byte completing in the same cycle as the RXDATA pop keeps rx_ready set
      if (soft_reset)                                           rx_ready <= 1'b0;
      else if (rx_done)                                         rx_ready <= 1'b1;
      else if (accept && !is_write && idx == CSR_RXDATA)        rx_ready <= 1'b0;
      if (rx_done) rx_data <= rx_byte;
    end
  end

  iob_system_sim_uart_phy u_phy (
    .clk        (clk_i),
    .rst_n      (arst_i),
    .cke        (cke_i),
    .soft_reset (soft_reset),
    .div        (div_q),
    .tx_start   (tx_start),
    .tx_data    (iob.iob_wdata[DATA_BITS-1:0]),
    .tx_busy    (tx_busy),
    .txd        (txd_o),
    .rx_en      (rx_en),
    .rxd        (rxd_i),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte)
  );

endmodule

// File: tb/tb_iob_system_sim_uart.sv
// Directed bench for the UART endpoint: CSR vector table plus hand-written
// serial-line sequences (TX frame, loopback, overrun, bad stop, glitch, reset).
module tb_iob_system_sim_uart;

  logic clk = 1'b0;
  logic cke = 1'b1;
  logic arst_n = 1'b0;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic txd, rxd;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vecs[14];

  iob_system_sim_uart_if #(.DATA_W(32), .ADDR_W(5)) iob ();

  iob_system_sim_uart #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i  (clk),
    .cke_i  (cke),
    .arst_i (arst_n),
    .iob    (iob),
    .txd_o  (txd),
    .rxd_i  (rxd)
  );

  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic wr, input logic [4:0] a, input logic [31:0] d, input string n);
    vecs[i].wr = wr; vecs[i].addr = a; vecs[i].data = d; vecs[i].name = n;
  endtask

  // Called at a negedge; request accepted at the following posedge
  task automatic csr_write(input logic [4:0] addr, input logic [31:0] data);
    iob.iob_valid = 1'b1; iob.iob_addr = addr; iob.iob_wdata = data; iob.iob_wstrb = 4'hF;
    @(negedge clk);
    iob.iob_valid = 1'b0; iob.iob_wstrb = 4'h0;
  endtask

  task automatic csr_read(input logic [4:0] addr, output logic [31:0] data, output logic rv);
    iob.iob_valid = 1'b1; iob.iob_addr = addr; iob.iob_wdata = '0; iob.iob_wstrb = 4'h0;
    @(negedge clk);
    iob.iob_valid = 1'b0;
    rv = iob.iob_rvalid;
    data = iob.iob_rdata;
  endtask

  task automatic rd_check(input logic [4:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    logic rv;
    csr_read(addr, d, rv);
    check({name, "_rvalid"}, 32'(rv), 32'd1);
    check(name, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rxd_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (div) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        rv;
    int          n;
    int          lows;
    logic [9:0]  frame;

    iob.iob_valid = 1'b0; iob.iob_addr = '0; iob.iob_wdata = '0; iob.iob_wstrb = '0;

    setv(0,  1'b0, 5'h14, 32'h0,  "txready_rst");
    setv(1,  1'b0, 5'h18, 32'h0,  "rxready_rst");
    setv(2,  1'b0, 5'h1C, 32'h0,  "rxdata_rst");
    setv(3,  1'b1, 5'h0C, 32'h1,  "wr_txen");
    setv(4,  1'b0, 5'h14, 32'h1,  "txready_en");
    setv(5,  1'b1, 5'h00, 32'h1,  "wr_srst1");
    setv(6,  1'b0, 5'h14, 32'h0,  "txready_srst");
    setv(7,  1'b1, 5'h00, 32'h0,  "wr_srst0");
    setv(8,  1'b0, 5'h14, 32'h1,  "txready_txen_kept");
    setv(9,  1'b0, 5'h0C, 32'h0,  "txen_reads_zero");
    setv(10, 1'b1, 5'h1C, 32'hFF, "wr_rxdata");
    setv(11, 1'b0, 5'h1C, 32'h0,  "rxdata_wr_ignored");
    setv(12, 1'b1, 5'h04, 32'h4,  "wr_div4");
    setv(13, 1'b0, 5'h04, 32'h0,  "div_reads_zero");

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(iob.iob_ready), 32'd0);
    check("rst_rvalid", 32'(iob.iob_rvalid), 32'd0);
    check("rst_rdata",  iob.iob_rdata, 32'd0);
    check("rst_txd",    32'(txd), 32'd1);
    arst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(iob.iob_ready), 32'd1);

    // CSR vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        csr_write(vecs[i].addr, vecs[i].data);
        check({vecs[i].name, "_no_rvalid"}, 32'(iob.iob_rvalid), 32'd0);
      end else begin
        rd_check(vecs[i].addr, vecs[i].data, vecs[i].name);
        @(negedge clk);
        check({vecs[i].name, "_pulse"}, 32'(iob.iob_rvalid), 32'd0);
      end
    end

    // TX 0x41 at DIV=4, dropped 0x99 while busy, TXREADY boundary at 40 cycles
    frame = {1'b1, 8'h41, 1'b0};
    csr_write(5'h08, 32'h41);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if (txd !== frame[i/4]) check($sformatf("tx41_cycle%0d", i), 32'(txd), 32'(frame[i/4]));
          @(negedge clk);
        end
        check("tx41_frame_done", 32'(txd), 32'd1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
          if (txd !== 1'b1) lows++;
          @(negedge clk);
        end
        check("tx_busy_write_dropped", 32'(lows), 32'd0);
      end
      begin
        logic [31:0] db;
        logic        rvb;
        csr_read(5'h14, db, rvb);
        check("txready_busy", db, 32'd0);
        csr_write(5'h08, 32'h99);
        repeat (37) @(negedge clk);
        csr_read(5'h14, db, rvb);
        check("txready_cycle40", db, 32'd0);
        csr_read(5'h14, db, rvb);
        check("txready_cycle41", db, 32'd1);
      end
    join

    // Loopback 0xA5 at DIV=8
    csr_write(5'h04, 32'd8);
    csr_write(5'h10, 32'd1);
    loop = 1'b1;
    repeat (4) @(negedge clk);
    csr_write(5'h08, 32'hA5);
    n = 0;
    d = '0;
    while (d[0] !== 1'b1 && n < 200) begin
      csr_read(5'h18, d, rv);
      n++;
    end
    check("rx_loop_seen", 32'(d[0]), 32'd1);
    check("rx_loop_latency", 32'(n >= 75 && n <= 90), 32'd1);
    rd_check(5'h1C, 32'hA5, "rx_loop_data");
    rd_check(5'h18, 32'h0, "rxready_after_pop");
    repeat (20) @(negedge clk);
    loop = 1'b0;
    repeat (4) @(negedge clk);

    // Overrun: second byte overwrites the first
    send_frame(8'h12, 1'b1, 8);
    send_frame(8'h34, 1'b1, 8);
    rd_check(5'h18, 32'h1, "rxready_two_frames");
    rd_check(5'h1C, 32'h34, "rxdata_overwrite");
    rd_check(5'h18, 32'h0, "rxready_cleared");

    // Stop bit 0 discards the frame
    send_frame(8'h55, 1'b0, 8);
    repeat (10) @(negedge clk);
    rd_check(5'h18, 32'h0, "rx_bad_stop");
    rd_check(5'h1C, 32'h34, "rxdata_kept");

    // Short low glitch is a false start; receiver still works afterwards
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (60) @(negedge clk);
    rd_check(5'h18, 32'h0, "rx_glitch");
    send_frame(8'hC3, 1'b1, 8);
    rd_check(5'h1C, 32'hC3, "rx_after_glitch");

    // Asynchronous reset in the middle of a TX frame
    csr_write(5'h04, 32'd4);
    csr_write(5'h08, 32'h00);
    repeat (10) @(negedge clk);
    check("txd_mid_frame", 32'(txd), 32'd0);
    #2 arst_n = 1'b0;
    #1;
    check("arst_txd_high", 32'(txd), 32'd1);
    check("arst_ready", 32'(iob.iob_ready), 32'd0);
    check("arst_rdata", iob.iob_rdata, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    rd_check(5'h14, 32'h0, "txready_after_arst");
    rd_check(5'h18, 32'h0, "rxready_after_arst");

    // DIV back at 0 behaves as 2: start + 8 zero bits = 18 low cycles
    csr_write(5'h0C, 32'd1);
    csr_write(5'h08, 32'h00);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (txd === 1'b0) lows++;
      @(negedge clk);
    end
    check("div0_low_cycles", 32'(lows), 32'd18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
